// File: rtl/prod_pkg.sv
// Shared definitions for the burst producer: FSM encoding and LFSR feedback taps.
package prod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Feedback taps d7, d5, d4, d3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] d);
    return {d[6:0], ^(d & LFSR_TAPS)};
  endfunction

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  function automatic logic [7:0] fix_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and advance-on-transfer.
module lfsr8
  import prod_pkg::*;
#(
  parameter logic [7:0] INIT = 8'h01
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       adv,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q <= INIT;
    end else if (load) begin
      q <= seed;
    end else if (adv) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/hs_prod.sv
// Valid/ready burst producer: NUM_BURSTS bursts of BURST_LEN LFSR words separated
// by GAP_LEN idle cycles, with a running mod-256 checksum of accepted words.
module hs_prod
  import prod_pkg::*;
#(
  parameter int         BURST_LEN  = 16,
  parameter int         GAP_LEN    = 2,
  parameter int         NUM_BURSTS = 4,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       start,
  input  logic       rdy,
  output logic       val,
  output logic [7:0] data,
  output logic [7:0] csum,
  output logic       done
);

  localparam logic [7:0] SEED_EFF   = fix_seed(SEED);
  localparam logic [7:0] LAST_WORD  = 8'(BURST_LEN - 1);
  localparam logic [7:0] LAST_BURST = 8'(NUM_BURSTS - 1);
  localparam logic [7:0] LAST_GAP   = 8'(GAP_LEN - 1);

  state_t     state_reg, state_next;
  logic [7:0] word_cnt_reg, burst_cnt_reg, gap_cnt_reg, csum_reg;
  logic [7:0] lfsr_q;
  logic       xfer, burst_end, run_end, begin_run;

  assign xfer      = (state_reg == SEND) && rdy;
  assign burst_end = xfer && (word_cnt_reg == LAST_WORD);
  assign run_end   = burst_end && (burst_cnt_reg == LAST_BURST);
  assign begin_run = start && ((state_reg == IDLE) || (state_reg == DONE));

  lfsr8 #(.INIT(SEED_EFF)) u_lfsr (
    .clk   (clk),
    .rst_b (rst_b),
    .load  (begin_run),
    .seed  (SEED_EFF),
    .adv   (xfer),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE, DONE: if (start) state_next = SEND;
      SEND: begin
        if (run_end) begin
          state_next = DONE;
        end else if (burst_end && (GAP_LEN != 0)) begin
          state_next = GAP;
        end
      end
      GAP: if (gap_cnt_reg == LAST_GAP) state_next = SEND;
    endcase
  end

  always_comb begin
    val  = 1'b0;
    data = 8'h00;
    done = 1'b0;
    unique case (state_reg)
      SEND: begin
        val  = 1'b1;
        data = lfsr_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Counters and checksum; the gap counter only runs while idling between bursts.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      word_cnt_reg  <= 8'h00;
      burst_cnt_reg <= 8'h00;
      gap_cnt_reg   <= 8'h00;
      csum_reg      <= 8'h00;
    end else if (begin_run) begin
      word_cnt_reg  <= 8'h00;
      burst_cnt_reg <= 8'h00;
      gap_cnt_reg   <= 8'h00;
      csum_reg      <= 8'h00;
    end else begin
      if (xfer) begin
        csum_reg <= csum_reg + lfsr_q;
        if (burst_end) begin
          word_cnt_reg  <= 8'h00;
          burst_cnt_reg <= burst_cnt_reg + 8'd1;
        end else begin
          word_cnt_reg <= word_cnt_reg + 8'd1;
        end
      end
      gap_cnt_reg <= (state_reg == GAP) ? gap_cnt_reg + 8'd1 : 8'h00;
    end
  end

  assign csum = csum_reg;

endmodule

// File: doc/hs_prod.md
HS_PROD -- requirements
Module: hs_prod

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16: transfers per burst, range 1..255.
REQ-002 SHALL have parameter GAP_LEN, default 2: idle cycles between bursts, range 0..255.
REQ-003 SHALL have parameter NUM_BURSTS, default 4: bursts per run, range 1..255.
REQ-004 SHALL have parameter SEED, default 8'hA5: initial LFSR value; 0 SHALL be replaced by 8'h01.
REQ-005 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_b, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: single-cycle request to begin a run.
REQ-008 SHALL have port rdy, input, 1: downstream ready.
REQ-009 SHALL have port val, output, 1: data valid.
REQ-010 SHALL have port data, output, 8: payload.
REQ-011 SHALL have port csum, output, 8: mod-256 sum of all transferred words in the current run.
REQ-012 SHALL have port done, output, 1: run complete.

Function
REQ-013 A transfer SHALL occur on a rising edge where val and rdy are both 1.
REQ-014 FSM states: IDLE, SEND, GAP, DONE.
REQ-015 IDLE: val=0; on start=1, go to SEND, load LFSR with SEED, and clear the burst counter, word counter and csum.
REQ-016 SEND: val=1 and data=LFSR.
- While rdy=0, data SHALL stay stable and val SHALL stay 1; val SHALL never be withdrawn before a transfer.
REQ-017 On each transfer, the LFSR SHALL advance: next = {d[6:0], d7^d5^d4^d3}.
REQ-018 On each transfer: csum <= csum + data (8-bit wrap); word counter increments.
REQ-019 On the transfer that completes BURST_LEN words:
- last burst (burst count = NUM_BURSTS): go to DONE;
- otherwise, if GAP_LEN=0: remain in SEND with val held 1, no bubble;
- otherwise: go to GAP.
REQ-020 GAP: val=0 for exactly GAP_LEN cycles, then SEND.
REQ-021 DONE: val=0, done=1.
- csum SHALL hold the run total.
- start=1 SHALL restart the run exactly as from IDLE; done falls in the same edge.
REQ-022 start SHALL be ignored in SEND and GAP.
REQ-023 rdy SHALL be ignored outside SEND.
REQ-024 Output latency: val SHALL rise on the first edge after start is sampled.
REQ-025 Throughput: with rdy held 1 and GAP_LEN=0, one word per cycle for the entire run.

Reset
REQ-026 While rst_b=0, outputs SHALL be: state=IDLE, val=0, data=0, csum=0, done=0, all counters 0, LFSR=SEED.
REQ-027 Reset asserted mid-burst SHALL abort the run immediately, with no partial transfer completing.

Structure
REQ-028 The FSM state encoding and the LFSR tap constant SHALL live in the shared package prod_pkg.
REQ-029 The LFSR SHALL be one sub-module, lfsr8, with ports clk, rst_b, load, seed, adv, q.
REQ-030 The counters and FSM SHALL be in hs_prod itself.

Verification
REQ-031 Default parameters, start pulse, rdy=1 -> first words A5, 4A, 95.
- 16 consecutive val cycles, then 2 idle cycles, per burst.
- done=1 after 64 transfers.
REQ-032 rdy toggled randomly -> every word is accepted exactly once, with data stable while val=1 and rdy=0.
- A stalled bench run matches the unstalled sequence.
REQ-033 csum check -> csum equals the bench's mod-256 sum of all observed transfers.
- A summing consumer attached to val&rdy and data reads the same value.
REQ-034 GAP_LEN=0, BURST_LEN=1, NUM_BURSTS=3, rdy=1 -> val high for exactly 3 cycles, then done=1.
REQ-035 rst_b pulsed low after the 5th transfer -> val=0, csum=0, IDLE at once.
- A new start replays from A5.
REQ-036 SEED=0, or start asserted during SEND -> first word is 01, or start is ignored, respectively.
- In DONE, start restarts the run and csum is cleared.
